// File: rtl/bilinear_interp.sv
// bilinear_interp: 4-tap Q1.16 bilinear filter over frame memory; define BILINEAR_RGB565_EN for per-channel RGB565 math.
// Latency: pop to vout_valid is 5+RD_LAT cycles; at best one pixel per 6+RD_LAT cycles.
// Backpressure: vout_ready low holds vout_dat/vout_valid and blocks pops; coo_valid cannot stall, so a full FIFO drops and sets fifo_ovf.
module bilinear_interp #(
    parameter int FIFO_DEPTH = 16,
    parameter int RD_LAT     = 2
) (
    input  logic        vin_clk,
    input  logic        rst_n,
    input  logic        frame_sync_n,
    input  logic        coo_valid,
    input  logic [15:0] coordinate_x,
    input  logic [15:0] coordinate_y,
    input  logic [16:0] coefficient1,
    input  logic [16:0] coefficient2,
    input  logic [16:0] coefficient3,
    input  logic [16:0] coefficient4,
    input  logic [15:0] vin_xres,
    input  logic [15:0] vin_yres,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [15:0] rd_dat,
    output logic [15:0] vout_dat,
    output logic        vout_valid,
    input  logic        vout_ready,
    output logic        fifo_ovf
);
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] c1;
        logic [16:0] c2;
        logic [16:0] c3;
        logic [16:0] c4;
    } req_t;

    typedef enum logic [1:0] {IDLE, RD, WAIT, OUT} state_t;

    state_t      state, state_nxt;
    req_t        fifo_wr_dat, fifo_rd_dat, req_q;
    logic        fifo_wr_rdy, fifo_rd_vld, pop, flush;
    logic [1:0]  rd_idx;
    logic [15:0] x1, y1, sel_x, sel_y;
    logic [RD_LAT-1:0] tag_vld;
    logic [1:0]  tag_idx [RD_LAT];
    logic        ret_vld, last_ret;
    logic [1:0]  ret_idx;
    logic [16:0] ret_coef;
    logic [15:0] result;

    function automatic logic [15:0] round_sat(input logic [34:0] a, input logic [15:0] maxv);
        logic [35:0] r;
        r = {1'b0, a} + 36'd32768;
        if (r[35:16] > {4'd0, maxv})
            return maxv;
        return r[31:16];
    endfunction

    assign flush       = !frame_sync_n;
    assign fifo_wr_dat = '{x: coordinate_x, y: coordinate_y, c1: coefficient1,
                           c2: coefficient2, c3: coefficient3, c4: coefficient4};

    sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .vin_clk (vin_clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_vld  (coo_valid && frame_sync_n),
        .wr_rdy  (fifo_wr_rdy),
        .wr_dat  (fifo_wr_dat),
        .rd_vld  (fifo_rd_vld),
        .rd_rdy  (pop),
        .rd_dat  (fifo_rd_dat)
    );

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)
            fifo_ovf <= 1'b0;
        else if (flush)
            fifo_ovf <= 1'b0;
        else if (coo_valid && !fifo_wr_rdy)
            fifo_ovf <= 1'b1;
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (flush)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (fifo_rd_vld && !vout_valid) begin
                pop       = 1'b1;
                state_nxt = RD;
            end
            RD:   if (rd_idx == 2'd3) state_nxt = WAIT;
            WAIT: if (last_ret) state_nxt = OUT;
            OUT:  if (vout_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Neighbour clamp is done in 17 bits so x=16'hFFFF cannot wrap to 0.
    assign x1    = ({1'b0, req_q.x} + 17'd1 >= {1'b0, vin_xres}) ? req_q.x : req_q.x + 16'd1;
    assign y1    = ({1'b0, req_q.y} + 17'd1 >= {1'b0, vin_yres}) ? req_q.y : req_q.y + 16'd1;
    assign sel_x = rd_idx[0] ? x1 : req_q.x;
    assign sel_y = rd_idx[1] ? y1 : req_q.y;

    assign rd_en      = (state == RD);
    assign rd_addr    = rd_en ? ({16'd0, sel_y} * {16'd0, vin_xres} + {16'd0, sel_x}) : 32'd0;
    assign vout_valid = (state == OUT);

    assign ret_vld  = tag_vld[RD_LAT-1];
    assign ret_idx  = tag_idx[RD_LAT-1];
    assign last_ret = ret_vld && (ret_idx == 2'd3);

    always_comb begin
        case (ret_idx)
            2'd0:    ret_coef = req_q.c1;
            2'd1:    ret_coef = req_q.c2;
            2'd2:    ret_coef = req_q.c3;
            default: ret_coef = req_q.c4;
        endcase
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            rd_idx   <= '0;
            vout_dat <= '0;
            tag_vld  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
        end else if (flush) begin
            req_q    <= '0;
            rd_idx   <= '0;
            vout_dat <= '0;
            tag_vld  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
        end else begin
            if (pop) begin
                req_q  <= fifo_rd_dat;
                rd_idx <= 2'd0;
            end else if (state == RD) begin
                rd_idx <= rd_idx + 2'd1;
            end
            // Tags ride alongside the memory latency so each word meets its own coefficient.
            tag_vld[0] <= rd_en;
            tag_idx[0] <= rd_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            if (last_ret)
                vout_dat <= result;
        end
    end

`ifdef BILINEAR_RGB565_EN
    logic [34:0] acc_r, acc_g, acc_b;
    logic [34:0] acc_r_nxt, acc_g_nxt, acc_b_nxt;
    logic [15:0] res_r, res_g, res_b;

    always_comb begin
        acc_r_nxt = acc_r + ({30'd0, rd_dat[15:11]} * {18'd0, ret_coef});
        acc_g_nxt = acc_g + ({29'd0, rd_dat[10:5]}  * {18'd0, ret_coef});
        acc_b_nxt = acc_b + ({30'd0, rd_dat[4:0]}   * {18'd0, ret_coef});
        res_r     = round_sat(acc_r_nxt, 16'd31);
        res_g     = round_sat(acc_g_nxt, 16'd63);
        res_b     = round_sat(acc_b_nxt, 16'd31);
        result    = (res_r << 11) | (res_g << 5) | res_b;
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (flush || pop) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (ret_vld) begin
            acc_r <= acc_r_nxt;
            acc_g <= acc_g_nxt;
            acc_b <= acc_b_nxt;
        end
    end
`else
    logic [34:0] acc, acc_nxt;

    always_comb begin
        acc_nxt = acc + ({19'd0, rd_dat} * {18'd0, ret_coef});
        result  = round_sat(acc_nxt, 16'hFFFF);
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (flush || pop)
            acc <= '0;
        else if (ret_vld)
            acc <= acc_nxt;
    end
`endif

endmodule

// sync_fifo: generic single-clock FIFO, valid/ready on both sides, DEPTH a power of 2.
// Latency: a word written at one edge is visible on rd_dat after that edge.
// Backpressure: wr_rdy drops when full unless a read drains a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             vin_clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign rd_vld = (count != '0);
    assign wr_rdy = (count != (AW+1)'(DEPTH)) || rd_rdy;
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge vin_clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bilinear_interp.sv
// Scoreboard bench for bilinear_interp: directed requests against a RD_LAT-delay memory model.
module tb_bilinear_interp;
    localparam int FIFO_DEPTH = 16;
    localparam int RD_LAT     = 2;

    logic        vin_clk = 1'b0;
    logic        rst_n;
    logic        frame_sync_n;
    logic        coo_valid;
    logic [15:0] coordinate_x, coordinate_y;
    logic [16:0] coefficient1, coefficient2, coefficient3, coefficient4;
    logic [15:0] vin_xres, vin_yres;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [15:0] rd_dat;
    logic [15:0] vout_dat;
    logic        vout_valid;
    logic        vout_ready;
    logic        fifo_ovf;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_dat_q  [$];
    logic [31:0] exp_addr_q [$];

    // mem_mode 0: pixel(i)=i, 1: all 16'hFFFF, 2: even F800 / odd 001F
    logic [1:0]        mem_mode;
    logic [RD_LAT-1:0] mem_vld;
    logic [31:0]       mem_addr [RD_LAT];

    always #5 vin_clk = ~vin_clk;

    bilinear_interp #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LAT     (RD_LAT)
    ) dut (
        .vin_clk      (vin_clk),
        .rst_n        (rst_n),
        .frame_sync_n (frame_sync_n),
        .coo_valid    (coo_valid),
        .coordinate_x (coordinate_x),
        .coordinate_y (coordinate_y),
        .coefficient1 (coefficient1),
        .coefficient2 (coefficient2),
        .coefficient3 (coefficient3),
        .coefficient4 (coefficient4),
        .vin_xres     (vin_xres),
        .vin_yres     (vin_yres),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_dat       (rd_dat),
        .vout_dat     (vout_dat),
        .vout_valid   (vout_valid),
        .vout_ready   (vout_ready),
        .fifo_ovf     (fifo_ovf)
    );

    always @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) mem_addr[i] <= '0;
        end else begin
            mem_vld[0]  <= rd_en;
            mem_addr[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                mem_vld[i]  <= mem_vld[i-1];
                mem_addr[i] <= mem_addr[i-1];
            end
        end
    end

    always_comb begin
        rd_dat = 16'hDEAD;
        if (mem_vld[RD_LAT-1]) begin
            case (mem_mode)
                2'd0:    rd_dat = mem_addr[RD_LAT-1][15:0];
                2'd1:    rd_dat = 16'hFFFF;
                default: rd_dat = mem_addr[RD_LAT-1][0] ? 16'h001F : 16'hF800;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge vin_clk) begin
        if (rst_n === 1'b1 && rd_en === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: rd_addr=%0d with no read pending", rd_addr);
            end else begin
                check("rd_addr", rd_addr, exp_addr_q.pop_front());
            end
        end
        if (rst_n === 1'b1 && vout_valid === 1'b1 && vout_ready === 1'b1) begin
            if (exp_dat_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL vout_unexpected: vout_dat=0x%0h with no output pending", vout_dat);
            end else begin
                check("vout_dat", 32'(vout_dat), 32'(exp_dat_q.pop_front()));
            end
        end
    end

    task automatic expect_px(input logic [31:0] a0, a1, a2, a3, input logic [15:0] d);
        exp_addr_q.push_back(a0);
        exp_addr_q.push_back(a1);
        exp_addr_q.push_back(a2);
        exp_addr_q.push_back(a3);
        exp_dat_q.push_back(d);
    endtask

    task automatic send(input logic [15:0] x, y, input logic [16:0] c1, c2, c3, c4);
        coo_valid    = 1'b1;
        coordinate_x = x;
        coordinate_y = y;
        coefficient1 = c1;
        coefficient2 = c2;
        coefficient3 = c3;
        coefficient4 = c4;
        @(posedge vin_clk); #1;
        coo_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_dat_q.size() != 0) && n < 200) begin
            @(posedge vin_clk); #1;
            n++;
        end
        check(name, 32'(exp_dat_q.size()), 32'd0);
        @(posedge vin_clk); #1;
    endtask

    task automatic wait_vout(input string name);
        int n = 0;
        while (vout_valid !== 1'b1 && n < 50) begin
            @(posedge vin_clk); #1;
            n++;
        end
        check(name, 32'(vout_valid), 32'd1);
    endtask

    initial begin
        int n;
        int rd_seen;
        int vld_seen;
        rst_n        = 1'b0;
        frame_sync_n = 1'b1;
        coo_valid    = 1'b0;
        coordinate_x = '0;
        coordinate_y = '0;
        coefficient1 = '0;
        coefficient2 = '0;
        coefficient3 = '0;
        coefficient4 = '0;
        vin_xres     = 16'd8;
        vin_yres     = 16'd8;
        vout_ready   = 1'b1;
        mem_mode     = 2'd0;
        repeat (3) @(posedge vin_clk);
        #1;
        check("rst_rd_en",      32'(rd_en),      32'd0);
        check("rst_rd_addr",    rd_addr,         32'd0);
        check("rst_vout_dat",   32'(vout_dat),   32'd0);
        check("rst_vout_valid", 32'(vout_valid), 32'd0);
        check("rst_fifo_ovf",   32'(fifo_ovf),   32'd0);
        rst_n = 1'b1;
        @(posedge vin_clk); #1;

        // single tap at (2,3), latency from the push edge
        expect_px(26, 27, 34, 35, 16'd26);
        send(16'd2, 16'd3, 17'd65536, 17'd0, 17'd0, 17'd0);
        n = 0;
        do begin
            @(posedge vin_clk); #1;
            n++;
        end while (vout_valid !== 1'b1 && n < 40);
        check("t1_latency", 32'(n), 32'(5 + RD_LAT));
        drain("t1_drain");

        // equal weights: 122/4 = 30.5 rounds up
        expect_px(26, 27, 34, 35, 16'd31);
        send(16'd2, 16'd3, 17'd16384, 17'd16384, 17'd16384, 17'd16384);
        drain("t2_drain");

        // corner clamp on both axes
        expect_px(63, 63, 63, 63, 16'd63);
        send(16'd7, 16'd7, 17'd32768, 17'd0, 17'd0, 17'd32768);
        drain("t3_drain");

        // right-edge clamp only
        expect_px(23, 23, 31, 31, 16'd23);
        send(16'd7, 16'd2, 17'd0, 17'd65536, 17'd0, 17'd0);
        drain("t3b_drain");

        // saturation with downstream stalled, second request must wait
        mem_mode   = 2'd1;
        vout_ready = 1'b0;
        expect_px(0, 1, 8, 9, 16'hFFFF);
        send(16'd0, 16'd0, 17'd65536, 17'd65536, 17'd0, 17'd0);
        wait_vout("t4_valid_rise");
        expect_px(1, 2, 9, 10, 16'hFFFF);
        send(16'd1, 16'd0, 17'd65536, 17'd65536, 17'd0, 17'd0);
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(vout_valid), 32'd1);
            check("t4_hold_dat",   32'(vout_dat),   32'hFFFF);
            if (rd_en === 1'b1) rd_seen++;
            @(posedge vin_clk); #1;
        end
        check("t4_no_pop", 32'(rd_seen), 32'd0);
        vout_ready = 1'b1;
        drain("t4_drain");

        // packed-pixel case: F800 and 001F blended half/half
        mem_mode = 2'd2;
`ifdef BILINEAR_RGB565_EN
        expect_px(26, 27, 34, 35, 16'h8010);
`else
        expect_px(26, 27, 34, 35, 16'h7C10);
`endif
        send(16'd2, 16'd3, 17'd32768, 17'd32768, 17'd0, 17'd0);
        drain("t5_drain");

        // overflow: park one result in OUT, then flood the FIFO
        mem_mode   = 2'd0;
        vout_ready = 1'b0;
        exp_addr_q.push_back(0);
        exp_addr_q.push_back(1);
        exp_addr_q.push_back(8);
        exp_addr_q.push_back(9);
        send(16'd0, 16'd0, 17'd65536, 17'd0, 17'd0, 17'd0);
        wait_vout("t6_valid_rise");
        for (int i = 0; i < FIFO_DEPTH; i++)
            send(16'd1, 16'd1, 17'd65536, 17'd0, 17'd0, 17'd0);
        check("t6_ovf_at_full", 32'(fifo_ovf), 32'd0);
        send(16'd1, 16'd1, 17'd65536, 17'd0, 17'd0, 17'd0);
        check("t6_ovf_set", 32'(fifo_ovf), 32'd1);
        repeat (3) @(posedge vin_clk);
        #1;
        check("t6_ovf_sticky", 32'(fifo_ovf), 32'd1);

        // flush, with requests presented during it that must be ignored
        frame_sync_n = 1'b0;
        coo_valid    = 1'b1;
        @(posedge vin_clk); #1;
        check("t6_flush_ovf",   32'(fifo_ovf),   32'd0);
        check("t6_flush_valid", 32'(vout_valid), 32'd0);
        check("t6_flush_dat",   32'(vout_dat),   32'd0);
        @(posedge vin_clk); #1;
        frame_sync_n = 1'b1;
        coo_valid    = 1'b0;
        vout_ready   = 1'b1;
        vld_seen     = 0;
        for (int i = 0; i < 30; i++) begin
            if (vout_valid === 1'b1) vld_seen++;
            @(posedge vin_clk); #1;
        end
        check("t6_fifo_empty", 32'(vld_seen), 32'd0);
        check("t6_ovf_clear",  32'(fifo_ovf), 32'd0);

        // recovery after flush
        expect_px(26, 27, 34, 35, 16'd26);
        send(16'd2, 16'd3, 17'd65536, 17'd0, 17'd0, 17'd0);
        drain("t7_drain");

        check("end_addr_q", 32'(exp_addr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
